// File: rtl/pipo_arb_pkg.sv
// Shared types and defaults for the PIPO load arbiter.
package pipo_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam int DEF_WIDTH       = 4;
  localparam int DEF_NREQ        = 4;
  localparam int DEF_HOLD_CYCLES = 2;

  // Index width for n requesters; never narrower than one bit.
  function automatic int ptr_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational masked round-robin picker: lowest set request at or above ptr,
// falling back to the lowest set request overall when none lie above ptr.
module rr_pick
  import pipo_arb_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int PW   = ptr_width(DEF_NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [PW-1:0]   index,
  output logic            any
);

  logic [NREQ-1:0] mask;
  logic [NREQ-1:0] masked;
  logic [NREQ-1:0] sel;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_mask
      assign mask[gi] = (gi >= int'(ptr));
    end
  endgenerate

  assign masked = req & mask;
  assign sel    = (|masked) ? masked : req;
  assign any    = |req;

  // Scan downward so the last hit, i.e. the lowest index, wins.
  always_comb begin
    grant = '0;
    index = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (sel[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        index    = PW'(i);
      end
    end
  end

endmodule

// File: rtl/pipo_load_arbiter.sv
// Round-robin load/hold arbiter in front of a shared PIPO register.
// Optional build macro PIPO_ARB_PRIO0_EN gives requester 0 absolute priority.
module pipo_load_arbiter
  import pipo_arb_pkg::*;
#(
  parameter int WIDTH       = DEF_WIDTH,
  parameter int NREQ        = DEF_NREQ,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req,
  input  logic [NREQ*WIDTH-1:0]     din,
  output logic [NREQ-1:0]           ack,
  output logic [WIDTH-1:0]          q,
  output logic                      q_valid,
  output logic [$clog2(NREQ)-1:0]   owner,
  output logic                      busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  state_t          state_reg;
  logic [PW-1:0]   ptr_reg;
  logic [CW-1:0]   cnt_reg;

  logic [NREQ-1:0] pick_req;
  logic [NREQ-1:0] rr_grant;
  logic [PW-1:0]   rr_idx;
  logic            rr_any;

  logic [NREQ-1:0] win_grant;
  logic [PW-1:0]   win_idx;
  logic            win_any;
  logic            prio_hit;

`ifdef PIPO_ARB_PRIO0_EN
  // Requester 0 bypasses the rotation; the rest rotate among themselves.
  assign pick_req  = {req[NREQ-1:1], 1'b0};
  assign prio_hit  = req[0];
  assign win_any   = req[0] | rr_any;
  assign win_idx   = req[0] ? '0 : rr_idx;
  assign win_grant = req[0] ? {{(NREQ-1){1'b0}}, 1'b1} : rr_grant;
`else
  assign pick_req  = req;
  assign prio_hit  = 1'b0;
  assign win_any   = rr_any;
  assign win_idx   = rr_idx;
  assign win_grant = rr_grant;
`endif

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_pick (
    .req   (pick_req),
    .ptr   (ptr_reg),
    .grant (rr_grant),
    .index (rr_idx),
    .any   (rr_any)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      cnt_reg   <= '0;
      ack       <= '0;
      q         <= '0;
      q_valid   <= 1'b0;
      owner     <= '0;
      busy      <= 1'b0;
    end else begin
      ack <= '0;
      case (state_reg)
        IDLE: begin
          q_valid <= 1'b0;
          busy    <= 1'b0;
          if (win_any) begin
            q         <= din[int'(win_idx)*WIDTH +: WIDTH];
            ack       <= win_grant;
            owner     <= win_idx;
            cnt_reg   <= CW'(HOLD_CYCLES - 1);
            q_valid   <= 1'b1;
            busy      <= 1'b1;
            state_reg <= HOLD;
            if (!prio_hit) begin
              ptr_reg <= (win_idx == PW'(NREQ - 1)) ? '0 : win_idx + 1'b1;
            end
          end
        end
        HOLD: begin
          if (cnt_reg != '0) begin
            cnt_reg <= cnt_reg - 1'b1;
          end else begin
            state_reg <= IDLE;
            q_valid   <= 1'b0;
            busy      <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/pipo_load_arbiter.md
Name: pipo_load_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit parallel-in/parallel-out holding register between NREQ requesters.
- Each granted requester loads its data word into the shared register. The value is then held stable for HOLD_CYCLES cycles so the downstream consumer can sample it.
- Sits in front of the PIPO register stage and replaces direct `d` drive with an arbitrated load/hold sequence.

Parameters:
- WIDTH, 4, data width of the shared register.
- NREQ, 4, number of requesters (≥2).
- HOLD_CYCLES, 2, cycles q is held valid per grant (≥1).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- req  input  NREQ  per-requester load request, level-sensitive.
- din  input  NREQ*WIDTH  requester data; slice i = din[i*WIDTH +: WIDTH].
- ack  output  NREQ  one-hot, one-cycle grant/load acknowledge.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  q holds a freshly granted word.
- owner  output  $clog2(NREQ)  index of the last granted requester.
- busy  output  1  arbiter in HOLD; no new grant possible.

Behaviour:
- Reset (reset=0, asynchronous, any state, mid-HOLD included) clears everything immediately:
  - q=0, q_valid=0, ack=0, owner=0, busy=0.
  - Internal round-robin pointer ptr=0, hold counter=0, state=IDLE.
  - A pending grant is lost; the requester must keep req high to be re-served.
- FSM states: IDLE, HOLD. All outputs are registered.
- IDLE, no req: remain in IDLE; q keeps its last value; q_valid=0; ack=0.
- IDLE, any req bit set at an edge, one edge performs all of:
  - Winner = first set req index searching ptr, ptr+1, …, NREQ-1, 0, …, ptr-1.
  - q ← din[winner]; ack[winner] ← 1 (other bits 0); owner ← winner.
  - ptr ← (winner+1) mod NREQ; counter ← HOLD_CYCLES-1.
  - q_valid ← 1; busy ← 1; state ← HOLD.
- HOLD, every cycle:
  - ack ← 0, so ack is exactly one cycle wide.
  - q is frozen; req and din are ignored.
- HOLD, counter≠0: counter decrements.
- HOLD, counter=0: state ← IDLE; q_valid ← 0; busy ← 0.
- Timing: q_valid is high for exactly HOLD_CYCLES cycles. Minimum grant-to-grant spacing is HOLD_CYCLES+1 cycles.
- Requester handshake:
  - Hold req and din stable until ack is observed.
  - req dropped before ack means the request is withdrawn and no grant is issued.
  - req still high in the cycle after ack is a new request.
- Simultaneous requests are resolved only by the round-robin order. No requester is granted twice while another requester's req is continuously asserted.
- ptr wraps from NREQ-1 to 0.

Optional Feature:
- Macro: PIPO_ARB_PRIO0_EN.
- Defined: requester 0 has fixed absolute priority. If req[0]=1 in IDLE, requester 0 wins regardless of ptr, and ptr is not updated by requester-0 grants. Requesters 1..NREQ-1 are round-robin among themselves.
- Undefined: pure round-robin over all NREQ requesters as specified above.

Decomposition:
- Package pipo_arb_pkg:
  - State enum (IDLE, HOLD).
  - Default WIDTH/NREQ/HOLD_CYCLES constants.
  - Pointer-width localparam function.
- Sub-module rr_pick:
  - Combinational masked round-robin picker.
  - Inputs: req, ptr. Outputs: one-hot grant, index, any.
  - Instantiated once; the FSM and registers stay in pipo_load_arbiter.

Test Plan:
- All tests use WIDTH=4, NREQ=4, HOLD_CYCLES=2.
1. Reset: hold reset=0 with req=4'b1111 → q=0, ack=0, q_valid=0, busy=0, owner=0. Release reset → first grant goes to requester 0.
2. Single request: req=4'b0010, din slice1=4'b1010 → ack=4'b0010 for one cycle; q=1010; owner=1; q_valid high exactly 2 cycles; then IDLE.
3. Full contention: req=4'b1111, din slices 0011/1100/1010/0101 held → grant order 0,1,2,3,0; acks 3 cycles apart; q follows 0011, 1100, 1010, 0101, 0011.
4. Pointer wrap: after a grant to requester 1 (ptr=2), assert req=4'b1001 → requester 3 wins, then requester 0.
5. Reset mid-HOLD: grant requester 2, assert reset=0 one cycle later → q=0 and q_valid=0 immediately (no clock edge). After release with req=4'b0100 still high → requester 2 is re-granted.
6. PIPO_ARB_PRIO0_EN: req=4'b0101 held continuously → defined: every grant to requester 0; undefined: grants alternate 0,2,0,2.
